contador_param: RTL and testbench
=================================

CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 12, counter width in bits (1..32).
REQ-002 Parameter MAX_COUNT, default 4095, modulus top value; SHALL satisfy MAX_COUNT <= 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 En  input  1  count enable.
REQ-006 load  input  1  synchronous parallel-load strobe.
REQ-007 load2  input  WIDTH  parallel-load value.
REQ-008 dir  input  1  count direction: 1 = up, 0 = down.
REQ-009 mode  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (SHALL behave as WRAP).
REQ-010 q  output  WIDTH  registered count value.
REQ-011 tc  output  1  registered terminal-count/wrap pulse.
REQ-012 done  output  1  registered one-shot completion flag.

Function
REQ-013 Terminal value: MAX_COUNT when dir=1, 0 when dir=0; evaluated from dir at the current edge.
REQ-014 Priority per edge: load > En count > hold.
REQ-015 load=1: q <= min(load2, MAX_COUNT); done <= 0; tc <= 0; returns to state COUNT; En ignored that cycle.
REQ-016 En=0, load=0: q, done hold; tc <= 0.
REQ-017 State COUNT, En=1, q != terminal: q <= q+1 (up) or q-1 (down); tc <= 0.
REQ-018 COUNT, En=1, q == terminal, WRAP/reserved: q <= 0 (up) or MAX_COUNT (down); tc <= 1 for exactly one cycle.
REQ-019 COUNT, En=1, q == terminal, SAT: q holds; tc <= 0; counting resumes if dir changes.
REQ-020 COUNT, En=1, q == terminal, ONESHOT: q holds; state -> HALT; done <= 1; tc <= 1 for one cycle.
REQ-021 HALT: q holds, done=1, tc=0 regardless of En, dir, mode; exit only via load (-> COUNT) or reset.
REQ-022 mode change while in HALT SHALL NOT leave HALT.
REQ-023 Loaded value above MAX_COUNT SHALL clamp to MAX_COUNT (no out-of-range q ever).
REQ-024 MAX_COUNT=0: q stays 0; WRAP with En=1 pulses tc every cycle.
REQ-025 q arithmetic is modulo MAX_COUNT+1; no intermediate overflow beyond WIDTH bits visible.
REQ-026 Outputs SHALL change only on clk rising edge or reset assertion; no combinational input-to-output path.

Reset
REQ-027 reset=0 SHALL immediately force q=0, tc=0, done=0, state COUNT, independent of clk.
REQ-028 Reset asserted mid-count or in HALT SHALL discard all progress; first edge after release with En=1, dir=1 yields q=1.
REQ-029 Release of reset is synchronised by the first clk rising edge; no count on the release itself.

Structure
REQ-030 Mode encodings (WRAP, SAT, ONESHOT) and state encodings (COUNT, HALT) SHALL reside in shared package contador_pkg.
REQ-031 Single module; no sub-module; next-value logic in one combinational block, one sequential block for q/tc/done/state.

Verification
REQ-032 WIDTH=12, MAX=4095, WRAP, dir=1, load 4094 then En=1 x3 -> q 4095, 0, 1; tc=1 only in cycle q=0.
REQ-033 WIDTH=4, MAX=9, WRAP, dir=0, q=0, En=1 -> q=9, tc=1 one cycle, then 8.
REQ-034 WIDTH=12, MAX=4095, SAT, dir=1, load 4095, En=1 x3 -> q stays 4095, tc=0; dir=0 next edge -> q=4094.
REQ-035 WIDTH=4, MAX=9, ONESHOT, dir=1, load 8, En=1 -> q=9 then HALT, done=1; further En/mode changes hold q=9; load 3 -> q=3, done=0.
REQ-036 WIDTH=4, MAX=9, load=1, En=1, load2=15 same edge -> q=9 (clamp, load wins); reset=0 mid-clock-cycle -> q=0, tc=0, done=0 immediately.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared encodings for the parameterised up/down counter.
//   mode_e  : counting behaviour selected by the 2-bit mode input
//   state_e : control state of the counter (free counting or halted)
package contador_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11   // decoded exactly like MODE_WRAP
  } mode_e;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

endpackage : contador_pkg

// File: rtl/contador_param.sv
// Parameterised modulo-(MAX_COUNT+1) up/down counter with wrap, saturate
// and one-shot behaviours.
//
// Parameters
//   WIDTH      counter width in bits (1..32)
//   MAX_COUNT  top value of the count range, must fit in WIDTH bits
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   En     in   count enable
//   load   in   synchronous parallel load strobe (wins over En)
//   load2  in   parallel load value, clamped to MAX_COUNT
//   dir    in   1 = count up, 0 = count down
//   mode   in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   q      out  registered count
//   tc     out  registered one-cycle terminal-count pulse
//   done   out  registered one-shot completion flag
module contador_param
  import contador_pkg::*;
#(
  parameter int          WIDTH     = 12,
  parameter int unsigned MAX_COUNT = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             load,
  input  logic [WIDTH-1:0] load2,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

  // Loaded values never leave the legal range, so q stays in 0..MAX_COUNT.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  state_e           state, state_nxt;
  mode_e            mode_c;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] term;
  logic             tc_nxt;
  logic             done_nxt;

  assign mode_c = mode_e'(mode);
  // Terminal value follows the direction presented at this edge.
  assign term   = dir ? MAX_Q : '0;

  always_comb begin
    q_nxt     = q;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    state_nxt = state;
    if (load) begin
      q_nxt     = clamp_load(load2);
      done_nxt  = 1'b0;
      state_nxt = ST_COUNT;
    end else if (state == ST_HALT) begin
      // Halted: everything frozen until a load or reset.
      done_nxt = 1'b1;
    end else if (En) begin
      if (q != term) begin
        q_nxt = dir ? q + WIDTH'(1) : q - WIDTH'(1);
      end else begin
        case (mode_c)
          MODE_SAT: begin
            q_nxt = q;
          end
          MODE_ONESHOT: begin
            done_nxt  = 1'b1;
            tc_nxt    = 1'b1;
            state_nxt = ST_HALT;
          end
          default: begin
            // Wrap to the opposite end of the range; handles MAX_COUNT=0 too.
            q_nxt  = dir ? '0 : MAX_Q;
            tc_nxt = 1'b1;
          end
        endcase
      end
    end
  end

  // Output register stage: all outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= ST_COUNT;
    end else begin
      q     <= q_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
      state <= state_nxt;
    end
  end

endmodule : contador_param

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param. Three instances share the
// stimulus: WIDTH=12/MAX=4095, WIDTH=4/MAX=9 and WIDTH=3/MAX=0. A
// behavioural model predicts each instance's {q, tc, done} whenever
// stimulus is driven; predictions are queued and compared after the edge.
module tb_contador_param;

  logic        clk;
  logic        reset;
  logic        En;
  logic        load;
  logic [11:0] ld;
  logic        dir;
  logic [1:0]  mode;

  logic [11:0] q12;
  logic [3:0]  q4;
  logic [2:0]  q0;
  logic        tc12, tc4, tc0;
  logic        done12, done4, done0;

  int n_chk;
  int n_fail;

  logic [13:0] exp_q[$];

  int mq[3];
  bit mtc[3];
  bit mdone[3];
  bit mhalt[3];
  int mx[3] = '{4095, 9, 0};
  int mw[3] = '{12, 4, 3};

  contador_param #(.WIDTH(12), .MAX_COUNT(4095)) u12 (
    .clk(clk), .reset(reset), .En(En), .load(load), .load2(ld),
    .dir(dir), .mode(mode), .q(q12), .tc(tc12), .done(done12)
  );

  contador_param #(.WIDTH(4), .MAX_COUNT(9)) u4 (
    .clk(clk), .reset(reset), .En(En), .load(load), .load2(ld[3:0]),
    .dir(dir), .mode(mode), .q(q4), .tc(tc4), .done(done4)
  );

  contador_param #(.WIDTH(3), .MAX_COUNT(0)) u0 (
    .clk(clk), .reset(reset), .En(En), .load(load), .load2(ld[2:0]),
    .dir(dir), .mode(mode), .q(q0), .tc(tc0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got q=%0d tc=%0b done=%0b, expected q=%0d tc=%0b done=%0b",
               tag, obs[13:2], obs[1], obs[0], exp[13:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [13:0] observe(input int i);
    case (i)
      0:       return {q12, tc12, done12};
      1:       return {8'd0, q4, tc4, done4};
      default: return {9'd0, q0, tc0, done0};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mtc[i] = 0; mdone[i] = 0; mhalt[i] = 0;
    end
  endtask

  // Next-state prediction using plain integer modulo arithmetic.
  task automatic model_edge();
    int term;
    int v;
    for (int i = 0; i < 3; i++) begin
      if (load) begin
        v = int'(ld) & ((1 << mw[i]) - 1);
        mq[i]    = (v > mx[i]) ? mx[i] : v;
        mtc[i]   = 0;
        mdone[i] = 0;
        mhalt[i] = 0;
      end else if (!En || mhalt[i]) begin
        mtc[i] = 0;
      end else begin
        term = dir ? mx[i] : 0;
        if (mq[i] != term) begin
          mq[i]  = dir ? (mq[i] + 1) % (mx[i] + 1) : (mq[i] + mx[i]) % (mx[i] + 1);
          mtc[i] = 0;
        end else if (mode == 2'b01) begin
          mtc[i] = 0;
        end else if (mode == 2'b10) begin
          mhalt[i] = 1; mdone[i] = 1; mtc[i] = 1;
        end else begin
          mq[i]  = dir ? (mq[i] + 1) % (mx[i] + 1) : (mq[i] + mx[i]) % (mx[i] + 1);
          mtc[i] = 1;
        end
      end
    end
  endtask

  task automatic push_exp();
    for (int i = 0; i < 3; i++) exp_q.push_back({12'(mq[i]), mtc[i], mdone[i]});
  endtask

  task automatic pop_cmp(input string tag);
    string names[3] = '{"max4095", "max9", "max0"};
    logic [13:0] e;
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s/%s: scoreboard empty, nothing expected", tag, names[i]);
      end else begin
        e = exp_q.pop_front();
        check({tag, "/", names[i]}, observe(i), e);
      end
    end
  endtask

  // Called just after a falling edge; drives, predicts, checks after the
  // next rising edge and returns on the following falling edge.
  task automatic cycle(input string tag, input bit e, input bit l, input int v,
                       input bit d, input logic [1:0] m);
    En = e; load = l; ld = 12'(v); dir = d; mode = m;
    model_edge();
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp(tag);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; En = 1'b0; load = 1'b0; ld = '0; dir = 1'b1; mode = 2'b00;
    model_reset();
    #2;
    push_exp();
    pop_cmp("reset_state");
    @(negedge clk);
    reset = 1'b1;

    cycle("idle_hold", 0, 0, 0, 1, 2'b00);

    // Wrap up through the top of the range.
    cycle("wrap_up_load", 0, 1, 4094, 1, 2'b00);
    cycle("wrap_up_1", 1, 0, 0, 1, 2'b00);
    cycle("wrap_up_2", 1, 0, 0, 1, 2'b00);
    cycle("wrap_up_3", 1, 0, 0, 1, 2'b00);

    // Wrap down through zero, reserved mode behaves as wrap.
    cycle("wrap_dn_load", 0, 1, 0, 0, 2'b00);
    cycle("wrap_dn_1", 1, 0, 0, 0, 2'b00);
    cycle("wrap_dn_2", 1, 0, 0, 0, 2'b11);
    cycle("rsvd_dn_load", 0, 1, 0, 0, 2'b11);
    cycle("rsvd_dn_1", 1, 0, 0, 0, 2'b11);

    // Saturation at the top, then resume downward.
    cycle("sat_load", 0, 1, 4095, 1, 2'b01);
    cycle("sat_1", 1, 0, 0, 1, 2'b01);
    cycle("sat_2", 1, 0, 0, 1, 2'b01);
    cycle("sat_3", 1, 0, 0, 1, 2'b01);
    cycle("sat_dirflip", 1, 0, 0, 0, 2'b01);

    // One-shot: reach terminal, halt, ignore everything except load.
    cycle("os_load", 0, 1, 8, 1, 2'b10);
    cycle("os_1", 1, 0, 0, 1, 2'b10);
    cycle("os_2", 1, 0, 0, 1, 2'b10);
    cycle("os_halt_1", 1, 0, 0, 1, 2'b10);
    cycle("os_halt_wrap", 1, 0, 0, 1, 2'b00);
    cycle("os_halt_dn", 1, 0, 0, 0, 2'b01);
    cycle("os_reload", 1, 1, 3, 1, 2'b10);
    cycle("os_count", 1, 0, 0, 1, 2'b10);

    // Load beats enable and clamps.
    cycle("clamp_load", 1, 1, 15, 1, 2'b00);
    cycle("clamp_next", 1, 0, 0, 1, 2'b00);

    // Asynchronous reset between clock edges.
    cycle("pre_reset", 1, 0, 0, 1, 2'b00);
    @(posedge clk);
    model_edge();
    push_exp();
    #1;
    pop_cmp("pre_reset_edge");
    #2;
    reset = 1'b0;
    model_reset();
    push_exp();
    #1;
    pop_cmp("async_reset");
    @(negedge clk);
    En = 1'b1; dir = 1'b1; load = 1'b0; mode = 2'b00;
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp("reset_held");
    @(negedge clk);
    reset = 1'b1;
    cycle("post_reset_1", 1, 0, 0, 1, 2'b00);
    cycle("post_reset_2", 1, 0, 0, 1, 2'b00);

    // Randomised traffic across all modes.
    for (int k = 0; k < 300; k++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_contador_param
